// File: rtl/sd_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_clk_pkg
//  Description : Shared constants for the SD clock generator. Holds the
//                state encodings and the default post-reset divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_clk_pkg;

    // Generator state encodings (2-bit, legacy-compatible values)
    localparam logic [1:0] c_STOPPED  = 2'd0;
    localparam logic [1:0] c_RUN_LOW  = 2'd1;
    localparam logic [1:0] c_RUN_HIGH = 2'd2;

    // Divider active after reset: slow enough for card identification
    localparam logic [7:0] c_RST_DIV = 8'd124;

endpackage : sd_clk_pkg
`default_nettype wire

// File: rtl/sd_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sd_clock_gen
//  Description : SD card clock generator. Divides CLK by a runtime divider
//                (half-period = div+1 CLK cycles), starts/stops the SD clock
//                cleanly, applies divider changes only at safe points, and
//                emits one-CLK strobes on each SD clock edge.
//  Ports       :
//    CLK          in   system clock
//    RST_N        in   synchronous active-low reset
//    DIVIDER      in   requested divider value
//    DIV_LOAD     in   1-cycle pulse capturing DIVIDER as pending divider
//    DIV_BUSY     out  pending divider not yet applied
//    CLK_EN       in   1 = run SD clock, 0 = stop it low
//    CLK_RUNNING  out  generator is not stopped
//    SD_CLK_O     out  generated SD clock (registered)
//    POS_STB      out  high in the first CLK cycle SD_CLK_O is high
//    NEG_STB      out  high in the first CLK cycle SD_CLK_O is low
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_clock_gen
    import sd_clk_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(c_RST_DIV)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DIV_W-1:0] DIVIDER,
    input  logic             DIV_LOAD,
    output logic             DIV_BUSY,
    input  logic             CLK_EN,
    output logic             CLK_RUNNING,
    output logic             SD_CLK_O,
    output logic             POS_STB,
    output logic             NEG_STB
);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;     // divider in use
    logic [DIV_W-1:0] r_div_nx;    // divider waiting for an apply point
    logic             r_pend;
    logic             r_first_stop; // set for the first cycle spent in STOPPED
    logic             r_running;
    logic             r_sd_clk;
    logic             r_pos_stb;
    logic             r_neg_stb;

    logic w_phase_end;
    logic w_fall;
    logic w_apply;

    assign w_phase_end = (r_cnt == r_div_q);
    assign w_fall      = (r_state == c_RUN_HIGH) && w_phase_end;
    // Divider may only change while cnt is 0 so the counter can never
    // overrun a newly shortened phase.
    assign w_apply     = w_fall || ((r_state == c_STOPPED) && r_first_stop);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= c_STOPPED;
            r_cnt        <= '0;
            r_div_q      <= RST_DIV;
            r_div_nx     <= RST_DIV;
            r_pend       <= 1'b0;
            r_first_stop <= 1'b1;
            r_running    <= 1'b0;
            r_sd_clk     <= 1'b0;
            r_pos_stb    <= 1'b0;
            r_neg_stb    <= 1'b0;
        end else begin
            r_pos_stb <= 1'b0;
            r_neg_stb <= 1'b0;

            // Divider holding registers. A load coinciding with an apply
            // point bypasses the pending register entirely.
            if (w_apply) begin
                if (DIV_LOAD) begin
                    r_div_q <= DIVIDER;
                end else if (r_pend) begin
                    r_div_q <= r_div_nx;
                end
                r_pend <= 1'b0;
            end else if (DIV_LOAD) begin
                r_div_nx <= DIVIDER;
                r_pend   <= 1'b1;
            end

            case (r_state)
                c_STOPPED: begin
                    r_sd_clk     <= 1'b0;
                    r_first_stop <= 1'b0;
                    if (CLK_EN) begin
                        r_state   <= c_RUN_LOW;
                        r_cnt     <= '0;
                        r_running <= 1'b1;
                    end
                end
                c_RUN_LOW: begin
                    if (w_phase_end) begin
                        r_cnt     <= '0;
                        r_sd_clk  <= 1'b1;
                        r_pos_stb <= 1'b1;
                        r_state   <= c_RUN_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RUN_HIGH: begin
                    // CLK_EN only matters here, so a high phase always
                    // completes and no runt pulse can appear.
                    if (w_phase_end) begin
                        r_cnt     <= '0;
                        r_sd_clk  <= 1'b0;
                        r_neg_stb <= 1'b1;
                        if (CLK_EN) begin
                            r_state <= c_RUN_LOW;
                        end else begin
                            r_state      <= c_STOPPED;
                            r_running    <= 1'b0;
                            r_first_stop <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_STOPPED;
                    r_cnt     <= '0;
                    r_sd_clk  <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign DIV_BUSY    = r_pend;
    assign CLK_RUNNING = r_running;
    assign SD_CLK_O    = r_sd_clk;
    assign POS_STB     = r_pos_stb;
    assign NEG_STB     = r_neg_stb;

endmodule : sd_clock_gen
`default_nettype wire

// File: tb/tb_sd_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_clock_gen
//  Description : Self-checking bench for sd_clock_gen. A phase-length model
//                tracks the expected SD clock every cycle; directed sections
//                pin phase lengths and latencies with literal values, then a
//                randomized section exercises loads, enables and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_clock_gen;

    logic       CLK;
    logic       RST_N;
    logic [7:0] DIVIDER;
    logic       DIV_LOAD;
    logic       DIV_BUSY;
    logic       CLK_EN;
    logic       CLK_RUNNING;
    logic       SD_CLK_O;
    logic       POS_STB;
    logic       NEG_STB;

    int total = 0;
    int bad   = 0;

    sd_clock_gen #(.DIV_W(8), .RST_DIV(8'd124)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .DIVIDER     (DIVIDER),
        .DIV_LOAD    (DIV_LOAD),
        .DIV_BUSY    (DIV_BUSY),
        .CLK_EN      (CLK_EN),
        .CLK_RUNNING (CLK_RUNNING),
        .SD_CLK_O    (SD_CLK_O),
        .POS_STB     (POS_STB),
        .NEG_STB     (NEG_STB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: tracks the level and how many CLK cycles remain in
    // the current phase; a phase always lasts div+1 cycles.
    // ------------------------------------------------------------------
    bit m_valid = 0;
    bit m_stopped, m_first, m_lvl, m_pos, m_neg, m_pend;
    int m_left, m_div, m_nx;
    bit m_fall, m_apply;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_valid = 1; m_stopped = 1; m_first = 1; m_lvl = 0;
            m_pos = 0; m_neg = 0; m_pend = 0; m_div = 124; m_nx = 124; m_left = 0;
        end else if (m_valid) begin
            m_fall  = !m_stopped && m_lvl && (m_left == 1);
            m_apply = m_fall || (m_stopped && m_first);
            m_pos = 0; m_neg = 0;
            if (m_apply) begin
                if (DIV_LOAD) m_div = int'(DIVIDER);
                else if (m_pend) m_div = m_nx;
                m_pend = 0;
            end else if (DIV_LOAD) begin
                m_nx = int'(DIVIDER); m_pend = 1;
            end
            if (m_stopped) begin
                m_first = 0;
                if (CLK_EN) begin m_stopped = 0; m_lvl = 0; m_left = m_div + 1; end
            end else if (m_left > 1) begin
                m_left--;
            end else if (!m_lvl) begin
                m_lvl = 1; m_pos = 1; m_left = m_div + 1;
            end else begin
                m_lvl = 0; m_neg = 1;
                if (CLK_EN) m_left = m_div + 1;
                else begin m_stopped = 1; m_first = 1; end
            end
        end
    end

    // One compare per cycle of all outputs against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            total++;
            if ({SD_CLK_O, POS_STB, NEG_STB, DIV_BUSY, CLK_RUNNING} !==
                {m_lvl, m_pos, m_neg, m_pend, !m_stopped}) begin
                bad++;
                $display("FAIL model_cmp t=%0t got sd/pos/neg/busy/run=%b%b%b%b%b want %b%b%b%b%b",
                         $time, SD_CLK_O, POS_STB, NEG_STB, DIV_BUSY, CLK_RUNNING,
                         m_lvl, m_pos, m_neg, m_pend, !m_stopped);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Ticks until the selected strobe is seen; n=-1 if it never comes.
    task automatic wait_stb(input bit neg, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (neg ? NEG_STB : POS_STB) begin
                n = i;
                break;
            end
        end
    endtask

    int n, k;
    bit seen;

    initial begin
        RST_N = 0; DIVIDER = 0; DIV_LOAD = 0; CLK_EN = 0;
        tick(); tick();
        chk("rst_sd",   int'(SD_CLK_O), 0);
        chk("rst_pos",  int'(POS_STB), 0);
        chk("rst_neg",  int'(NEG_STB), 0);
        chk("rst_busy", int'(DIV_BUSY), 0);
        chk("rst_run",  int'(CLK_RUNNING), 0);
        RST_N = 1;

        // 1: divider 0 -> SD clock toggles every CLK
        DIVIDER = 8'd0; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        CLK_EN = 1;
        tick(); tick();
        chk("t1_first_high", int'(SD_CLK_O), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_sd", int'(SD_CLK_O), (i % 2 == 0) ? 0 : 1);
            chk("t1_stb", int'({POS_STB, NEG_STB}), (i % 2 == 0) ? 1 : 2);
        end

        // 2: divider 3 -> 4 high / 4 low, rise 4 CLK after enable sampled
        CLK_EN = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!CLK_RUNNING) begin seen = 1; break; end
        end
        chk("t2_stopped", int'(seen), 1);
        DIVIDER = 8'd3; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        chk("t2_busy_direct", int'(DIV_BUSY), 0);
        CLK_EN = 1;
        wait_stb(0, 50, n);
        chk("t2_rise_latency", n - 1, 4);
        chk("t2_pos_high", int'(SD_CLK_O), 1);
        wait_stb(1, 50, n);
        chk("t2_high_len", n, 4);
        wait_stb(0, 50, n);
        chk("t2_low_len", n, 4);

        // 3: load 1 at cnt=1 of high phase; high stays 4, next low is 2
        tick();
        DIVIDER = 8'd1; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        chk("t3_busy", int'(DIV_BUSY), 1);
        wait_stb(1, 50, n);
        chk("t3_high_len", n + 2, 4);
        chk("t3_busy_drop", int'(DIV_BUSY), 0);
        wait_stb(0, 50, n);
        chk("t3_low_len", n, 2);

        // 4: back to divider 3, then stop at cnt=0 of a high phase
        DIVIDER = 8'd3; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        wait_stb(1, 50, n);
        chk("t4_old_high_rest", n, 1);
        wait_stb(0, 50, n);
        chk("t4_new_low_len", n, 4);
        CLK_EN = 0;
        wait_stb(1, 50, n);
        chk("t4_high_len", n, 4);
        chk("t4_sd_low", int'(SD_CLK_O), 0);
        chk("t4_run_off", int'(CLK_RUNNING), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (POS_STB || NEG_STB || SD_CLK_O) seen = 1;
        end
        chk("t4_quiet", int'(seen), 0);
        CLK_EN = 1;
        wait_stb(0, 50, n);
        chk("t4_restart_latency", n - 1, 4);

        // 5: reset mid high phase with a pending divider
        DIVIDER = 8'd9; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        chk("t5_busy_pre", int'(DIV_BUSY), 1);
        tick();
        RST_N = 0; tick();
        chk("t5_sd",   int'(SD_CLK_O), 0);
        chk("t5_stb",  int'({POS_STB, NEG_STB}), 0);
        chk("t5_busy", int'(DIV_BUSY), 0);
        RST_N = 1;
        wait_stb(0, 400, n);
        chk("t5_rise_latency", n - 1, 125);
        wait_stb(0, 600, n);
        chk("t5_period", n, 250);

        // 6: load 7 in the falling-transition cycle
        repeat (124) tick();
        DIVIDER = 8'd7; DIV_LOAD = 1; tick(); DIV_LOAD = 0;
        chk("t6_neg", int'(NEG_STB), 1);
        chk("t6_busy", int'(DIV_BUSY), 0);
        seen = 0; n = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (DIV_BUSY) seen = 1;
            if (POS_STB) begin n = i; break; end
        end
        chk("t6_low_len", n, 8);
        chk("t6_busy_never", int'(seen), 0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            RST_N    = ($urandom_range(0, 299) != 0);
            DIV_LOAD = ($urandom_range(0, 14) == 0);
            k        = $urandom_range(0, 9);
            DIVIDER  = (k == 0) ? 8'($urandom_range(8, 30)) : 8'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) CLK_EN = ~CLK_EN;
            tick();
        end
        DIV_LOAD = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sd_clock_gen
`default_nettype wire
